fpu_arbiter: RTL and testbench

- Shares one fpu instance (clk, rst, A, B, op, start, R, done) among NREQ requesters using round-robin.
- Accepts one operation at a time, issues it to the FPU, waits for done, and returns the result to the requester that issued it.
- A watchdog aborts the wait if the FPU never raises done.
- Sits between the client blocks (sequencers, DMA, CPU port) and the single FPU datapath.

---
 rtl/fpu_arbiter_if.sv | 36 +++
 rtl/fpu_arbiter.sv | 129 ++++++++++++
 tb/tb_fpu_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_arbiter_if.sv
// fpu_arbiter_if: requester-side bundle of the shared-FPU arbiter.
// Operand/opcode buses are packed per requester, slice i at [W*i +: W].
interface fpu_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [32*NREQ-1:0]   req_a;
  logic [32*NREQ-1:0]   req_b;
  logic [2*NREQ-1:0]    req_op;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      resp_valid;
  logic [31:0]          resp_r;
  logic                 resp_err;

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    output req_op,
    input  req_ready,
    input  resp_valid,
    input  resp_r,
    input  resp_err
  );

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  req_op,
    output req_ready,
    output resp_valid,
    output resp_r,
    output resp_err
  );
endinterface

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin sharing of one FPU among NREQ clients,
// one operation in flight, with a watchdog on the FPU done.
module fpu_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  fpu_arbiter_if.slave bus,
  output logic         busy,
  output logic [31:0]  fpu_A,
  output logic [31:0]  fpu_B,
  output logic [1:0]   fpu_op,
  output logic         fpu_start,
  input  logic [31:0]  fpu_R,
  input  logic         fpu_done
);
  localparam int GW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [31:0]   QNAN  = 32'h7FC0_0000;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GLAST = GW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] win;
  logic [GW-1:0] cand;
  logic          found;
  logic [TW-1:0] timer;

  logic [31:0] a_arr  [NREQ];
  logic [31:0] b_arr  [NREQ];
  logic [1:0]  op_arr [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i]  = bus.req_a[32*i +: 32];
      b_arr[i]  = bus.req_b[32*i +: 32];
      op_arr[i] = bus.req_op[2*i +: 2];
    end
  end

  // Search starts just past the last grant, so it has lowest priority.
  always_comb begin
    found = 1'b0;
    win   = last_grant;
    cand  = last_grant;
    for (int i = 0; i < NREQ; i++) begin
      cand = (cand == GLAST) ? '0 : cand + 1'b1;
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (found) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (fpu_done || timer == TLAST) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Ready is masked while reset is held so nothing looks accepted.
  always_comb begin
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    if (state == IDLE && rst && found)
      bus.req_ready[win] = 1'b1;
    if (state == RESP)
      bus.resp_valid[last_grant] = 1'b1;
  end

  assign busy      = (state != IDLE);
  assign fpu_start = (state == ISSUE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpu_A        <= '0;
      fpu_B        <= '0;
      fpu_op       <= '0;
      bus.resp_r   <= '0;
      bus.resp_err <= 1'b0;
      timer        <= '0;
      last_grant   <= GLAST;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            fpu_A      <= a_arr[win];
            fpu_B      <= b_arr[win];
            fpu_op     <= op_arr[win];
            last_grant <= win;
          end
        end
        ISSUE: timer <= '0;
        WAIT: begin
          if (fpu_done) begin
            bus.resp_r   <= fpu_R;
            bus.resp_err <= 1'b0;
          end else if (timer == TLAST) begin
            bus.resp_r   <= QNAN;
            bus.resp_err <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: directed stimulus, transaction-level reference model
// checked every cycle, plus literal latency/result/grant-order pins.
module tb_fpu_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        busy;
  logic        fpu_start;
  logic        fpu_done;
  logic [31:0] fpu_A;
  logic [31:0] fpu_B;
  logic [31:0] fpu_R;
  logic [1:0]  fpu_op;

  fpu_arbiter_if #(.NREQ(NREQ)) bus ();

  fpu_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .fpu_A    (fpu_A),
    .fpu_B    (fpu_B),
    .fpu_op   (fpu_op),
    .fpu_start(fpu_start),
    .fpu_R    (fpu_R),
    .fpu_done (fpu_done)
  );

  always #5 clk = ~clk;

  logic [31:0]     sa  [NREQ];
  logic [31:0]     sb  [NREQ];
  logic [1:0]      sop [NREQ];
  logic [NREQ-1:0] req_valid = '0;

  always_comb begin
    bus.req_valid = req_valid;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[32*i +: 32] = sa[i];
      bus.req_b[32*i +: 32] = sb[i];
      bus.req_op[2*i +: 2]  = sop[i];
    end
  end

  // FPU stand-in: done fpu_delay cycles after start (0 = never).
  int          fpu_delay = 0;
  int          fpu_cnt   = -1;
  logic [31:0] fpu_res   = '0;
  logic        done_m    = 1'b0;
  logic        stray     = 1'b0;
  assign fpu_done = done_m | stray;
  assign fpu_R    = fpu_res;

  always @(posedge clk) begin
    logic st;
    st = fpu_start;
    #1;
    if (!rst) fpu_cnt = -1;
    else if (st && fpu_delay > 0) fpu_cnt = fpu_delay - 1;
    else if (fpu_cnt >= 0) fpu_cnt = fpu_cnt - 1;
    done_m = (fpu_cnt == 0);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: one transaction, timed by cycle windows.
  int          cyc        = 0;
  bit          m_inflight = 0;
  int          m_owner    = 0;
  int          m_acc      = 0;
  int          m_resp_at  = -1;
  int          m_last     = NREQ - 1;
  logic [31:0] m_a        = '0;
  logic [31:0] m_b        = '0;
  logic [1:0]  m_op       = '0;
  logic [31:0] m_r        = '0;
  logic        m_err      = 1'b0;
  int          pick;
  logic [NREQ-1:0] e_ready;
  logic [NREQ-1:0] e_rv;

  int              grants[$];
  int              resp_cnt    = 0;
  int              resp_cyc    = 0;
  int              start_cyc   = 0;
  int              acc_cyc     = 0;
  logic [31:0]     resp_r_seen = '0;
  logic            resp_e_seen = 1'b0;
  logic [NREQ-1:0] resp_v_seen = '0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      m_inflight = 0;
      m_last     = NREQ - 1;
      m_resp_at  = -1;
      m_a        = '0;
      m_b        = '0;
      m_op       = '0;
      m_r        = '0;
      m_err      = 1'b0;
    end
    pick = -1;
    if (rst && !m_inflight) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (pick < 0 && req_valid[(m_last + k) % NREQ])
          pick = (m_last + k) % NREQ;
      end
    end
    e_ready = '0;
    e_rv    = '0;
    if (pick >= 0) e_ready[pick] = 1'b1;
    if (m_inflight && cyc == m_resp_at) e_rv[m_owner] = 1'b1;

    chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
    chk("resp_valid", 32'(bus.resp_valid), 32'(e_rv));
    chk("busy", 32'(busy), 32'(m_inflight));
    chk("fpu_start", 32'(fpu_start),
        32'(m_inflight && cyc == m_acc + 1));
    chk("fpu_A", fpu_A, m_a);
    chk("fpu_B", fpu_B, m_b);
    chk("fpu_op", 32'(fpu_op), 32'(m_op));
    chk("resp_r", bus.resp_r, m_r);
    chk("resp_err", 32'(bus.resp_err), 32'(m_err));

    for (int i = 0; i < NREQ; i++)
      if (bus.req_ready[i]) grants.push_back(i);
    if (bus.req_ready != '0) acc_cyc = cyc;
    if (fpu_start) start_cyc = cyc;
    if (bus.resp_valid != '0) begin
      resp_cnt++;
      resp_cyc    = cyc;
      resp_r_seen = bus.resp_r;
      resp_e_seen = bus.resp_err;
      resp_v_seen = bus.resp_valid;
    end

    if (rst) begin
      if (m_inflight) begin
        if (cyc == m_resp_at) begin
          m_inflight = 0;
        end else if (m_resp_at < 0 && cyc >= m_acc + 2) begin
          if (fpu_done) begin
            m_resp_at = cyc + 1;
            m_r       = fpu_R;
            m_err     = 1'b0;
          end else if (cyc == m_acc + 1 + TIMEOUT) begin
            m_resp_at = cyc + 1;
            m_r       = 32'h7FC0_0000;
            m_err     = 1'b1;
          end
        end
      end else if (pick >= 0) begin
        m_inflight = 1;
        m_owner    = pick;
        m_acc      = cyc;
        m_last     = pick;
        m_resp_at  = -1;
        m_a        = sa[pick];
        m_b        = sb[pick];
        m_op       = sop[pick];
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [NREQ-1:0] mask);
    int n0 = grants.size();
    req_valid = mask;
    for (int k = 0; k < 50; k++) begin
      step(1);
      if (grants.size() > n0) break;
    end
    if (grants.size() <= n0) begin
      checks++;
      errors++;
      $display("FAIL issue: no grant for mask %b", mask);
    end
    req_valid = '0;
  endtask

  task automatic wait_resp(input int budget);
    int n0 = resp_cnt;
    for (int k = 0; k < budget; k++) begin
      step(1);
      if (resp_cnt > n0) break;
    end
    if (resp_cnt <= n0) begin
      checks++;
      errors++;
      $display("FAIL wait_resp: none within %0d cycles", budget);
    end
  endtask

  task automatic wait_grants(input int n, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (grants.size() >= n) break;
      step(1);
    end
    if (grants.size() < n) begin
      checks++;
      errors++;
      $display("FAIL wait_grants: %0d of %0d", grants.size(), n);
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (!busy) break;
      step(1);
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: still busy after %0d", budget);
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b0;
    step(1);
    rst = 1'b1;
  endtask

  int exp_rr1 [5];
  int exp_rr2 [4];
  int n_resp;

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      sa[i]  = 32'h1000_0000 + 32'(i);
      sb[i]  = 32'h2000_0000 + 32'(i);
      sop[i] = 2'(i);
    end
    exp_rr1 = '{0, 1, 2, 3, 0};
    exp_rr2 = '{0, 1, 3, 0};

    // reset with all requesting, then single op on req0
    sa[0]     = 32'h3F80_0000;
    sb[0]     = 32'h4000_0000;
    sop[0]    = 2'b00;
    fpu_delay = 4;
    fpu_res   = 32'h4040_0000;
    rst       = 1'b0;
    req_valid = 4'b1111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_fpu_A", fpu_A, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("first_ready", 32'(bus.req_ready), 32'h1);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_resp(20);
    chk("op_start_lat", 32'(start_cyc - acc_cyc), 32'd1);
    chk("op_resp_lat", 32'(resp_cyc - acc_cyc), 32'd6);
    chk("op_r", resp_r_seen, 32'h4040_0000);
    chk("op_err", 32'(resp_e_seen), 32'h0);
    chk("op_rv", 32'(resp_v_seen), 32'h1);

    // round-robin, all held
    fpu_delay = 1;
    pulse_rst();
    grants.delete();
    req_valid = 4'b1111;
    wait_grants(5, 60);
    req_valid = '0;
    wait_idle(20);
    for (int k = 0; k < 5; k++)
      chk($sformatf("rr1_%0d", k), 32'(grants[k]), 32'(exp_rr1[k]));

    // round-robin with req2 dropped after the first grant
    pulse_rst();
    grants.delete();
    req_valid = 4'b1111;
    wait_grants(1, 20);
    req_valid = 4'b1011;
    wait_grants(4, 60);
    req_valid = '0;
    wait_idle(20);
    for (int k = 0; k < 4; k++)
      chk($sformatf("rr2_%0d", k), 32'(grants[k]), 32'(exp_rr2[k]));

    // timeout: done never comes
    fpu_delay = 0;
    issue(4'b0100);
    wait_resp(100);
    chk("to_lat", 32'(resp_cyc - start_cyc), 32'd65);
    chk("to_r", resp_r_seen, 32'h7FC0_0000);
    chk("to_err", 32'(resp_e_seen), 32'h1);
    chk("to_rv", 32'(resp_v_seen), 32'h4);
    chk("to_busy_after", 32'(busy), 32'h0);

    // done coincides with watchdog expiry
    fpu_delay = TIMEOUT;
    fpu_res   = 32'h1234_5678;
    issue(4'b1000);
    wait_resp(100);
    chk("exp_lat", 32'(resp_cyc - start_cyc), 32'd65);
    chk("exp_r", resp_r_seen, 32'h1234_5678);
    chk("exp_err", 32'(resp_e_seen), 32'h0);

    // stray done in IDLE
    n_resp = resp_cnt;
    stray  = 1'b1;
    step(2);
    stray  = 1'b0;
    step(1);
    chk("stray_idle_busy", 32'(busy), 32'h0);
    chk("stray_idle_resp", 32'(resp_cnt), 32'(n_resp));

    // stray done in ISSUE
    fpu_delay = 3;
    fpu_res   = 32'hCAFE_0001;
    req_valid = 4'b0010;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (fpu_start) break;
    end
    stray = 1'b1;
    step(1);
    stray     = 1'b0;
    req_valid = '0;
    wait_resp(20);
    chk("stray_iss_lat", 32'(resp_cyc - acc_cyc), 32'd5);
    chk("stray_iss_r", resp_r_seen, 32'hCAFE_0001);

    // reset while waiting on the FPU
    fpu_delay = 10;
    issue(4'b0001);
    step(2);
    n_resp = resp_cnt;
    pulse_rst();
    chk("rstw_busy", 32'(busy), 32'h0);
    step(12);
    chk("rstw_no_resp", 32'(resp_cnt), 32'(n_resp));
    fpu_delay = 4;
    fpu_res   = 32'h0BAD_F00D;
    issue(4'b0010);
    wait_resp(20);
    chk("rstw_lat", 32'(resp_cyc - acc_cyc), 32'd6);
    chk("rstw_rv", 32'(resp_v_seen), 32'h2);
    chk("rstw_r", resp_r_seen, 32'h0BAD_F00D);

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
